// File: rtl/noc_host_bridge.sv
// Host bridge on the mesh external NoC port: packs host write commands into
// head/body/tail flits and unpacks inbound flits into tagged payload beats.
module noc_host_bridge #(
  parameter int         FLIT_W  = 64,
  parameter logic [3:0] HOST_ID = 4'hF,
  parameter int         ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_dest,
  input  logic [31:0]       cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [31:0]       wd_data,
  output logic [FLIT_W-1:0] noc_tx_flit,
  output logic              noc_tx_valid,
  input  logic              noc_tx_ready,
  input  logic [FLIT_W-1:0] noc_rx_flit,
  input  logic              noc_rx_valid,
  output logic              noc_rx_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [3:0]        rsp_src,
  output logic              rsp_last,
  output logic              rsp_empty,
  output logic              tx_busy,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic {TX_IDLE, TX_BODY} tx_state_t;
  typedef enum logic {RX_WAIT_HEAD, RX_PAYLOAD} rx_state_t;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  tx_state_t  tx_state;
  rx_state_t  rx_state;
  logic       active;
  logic [3:0] tx_dest;
  logic [7:0] tx_len;
  logic [7:0] tx_idx;
  logic [3:0] rx_src;
  logic       tx_free;
  logic       rsp_free;
  logic       cmd_fire;
  logic       wd_fire;
  logic       rx_fire;
  logic       rx_err;
  logic       tx_last_word;
  logic [1:0] rx_type;
  logic       rx_unused;

  // Handshakes stay low while in reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active <= 1'b0;
    else        active <= 1'b1;
  end

  assign tx_free      = !noc_tx_valid || noc_tx_ready;
  assign cmd_ready    = active && (tx_state == TX_IDLE) && tx_free;
  assign wd_ready     = active && (tx_state == TX_BODY) && tx_free;
  assign cmd_fire     = cmd_valid && cmd_ready;
  assign wd_fire      = wd_valid && wd_ready;
  assign tx_last_word = (tx_idx == tx_len - 8'd1);
  assign tx_busy      = (tx_state != TX_IDLE) || noc_tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state     <= TX_IDLE;
      noc_tx_valid <= 1'b0;
      noc_tx_flit  <= '0;
      tx_dest      <= '0;
      tx_len       <= '0;
      tx_idx       <= '0;
    end else begin
      if (noc_tx_ready) noc_tx_valid <= 1'b0;
      case (tx_state)
        TX_IDLE: if (cmd_fire) begin
          tx_dest      <= cmd_dest;
          tx_len       <= cmd_len;
          tx_idx       <= '0;
          noc_tx_valid <= 1'b1;
          noc_tx_flit  <= {(cmd_len == 8'd0) ? T_SINGLE : T_HEAD, cmd_dest, HOST_ID,
                           cmd_len, 14'd0, cmd_addr};
          if (cmd_len != 8'd0) tx_state <= TX_BODY;
        end
        TX_BODY: if (wd_fire) begin
          noc_tx_valid <= 1'b1;
          noc_tx_flit  <= {tx_last_word ? T_TAIL : T_BODY, tx_dest, HOST_ID,
                           14'd0, tx_idx, wd_data};
          tx_idx       <= tx_idx + 8'd1;
          if (tx_last_word) tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // Headers are absorbed without a beat, so they may pass while the rsp slot is full.
  assign rx_type      = noc_rx_flit[63:62];
  assign rsp_free     = !rsp_valid || rsp_ready;
  assign noc_rx_ready = active && (rsp_free || (rx_state == RX_WAIT_HEAD && rx_type == T_HEAD));
  assign rx_fire      = noc_rx_valid && noc_rx_ready;
  assign rx_err       = ((rx_state == RX_PAYLOAD) == rx_type[0]);
  assign rx_unused    = ^{noc_rx_flit[61:58], noc_rx_flit[53:32]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_WAIT_HEAD;
      rx_src    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_src   <= '0;
      rsp_last  <= 1'b0;
      rsp_empty <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (rsp_ready) rsp_valid <= 1'b0;
      if (rx_fire) begin
        if (rx_err && err_cnt != '1) err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
        case (rx_type)
          T_HEAD: begin
            rx_src   <= noc_rx_flit[57:54];
            rx_state <= RX_PAYLOAD;
          end
          T_SINGLE: begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_src   <= noc_rx_flit[57:54];
            rsp_last  <= 1'b1;
            rsp_empty <= 1'b1;
            rx_state  <= RX_WAIT_HEAD;
          end
          default: if (rx_state == RX_PAYLOAD) begin
            rsp_valid <= 1'b1;
            rsp_data  <= noc_rx_flit[31:0];
            rsp_src   <= rx_src;
            rsp_last  <= (rx_type == T_TAIL);
            rsp_empty <= 1'b0;
            if (rx_type == T_TAIL) rx_state <= RX_WAIT_HEAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noc_host_bridge.sv
// Directed and randomized checks of noc_host_bridge against a flit/beat model
// derived from the packet format rules.
module tb_noc_host_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_dest;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [63:0] noc_tx_flit;
  logic        noc_tx_valid, noc_tx_ready;
  logic [63:0] noc_rx_flit;
  logic        noc_rx_valid, noc_rx_ready;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_src;
  logic        rsp_last, rsp_empty, tx_busy;
  logic [7:0]  err_cnt;

  noc_host_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .noc_tx_flit(noc_tx_flit), .noc_tx_valid(noc_tx_valid), .noc_tx_ready(noc_tx_ready),
    .noc_rx_flit(noc_rx_flit), .noc_rx_valid(noc_rx_valid), .noc_rx_ready(noc_rx_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_src(rsp_src), .rsp_last(rsp_last), .rsp_empty(rsp_empty),
    .tx_busy(tx_busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Sink-side readiness: either directed by the main sequence or random backpressure.
  logic tx_auto = 1'b0, tx_man = 1'b1, tx_rand = 1'b1;
  logic rsp_auto = 1'b0, rsp_man = 1'b1, rsp_rand = 1'b1;
  int   tx_bp = 0, rsp_bp = 0;
  assign noc_tx_ready = tx_auto ? tx_rand : tx_man;
  assign rsp_ready    = rsp_auto ? rsp_rand : rsp_man;

  always @(negedge clk) begin
    tx_rand  = ($urandom_range(99) >= tx_bp);
    rsp_rand = ($urandom_range(99) >= rsp_bp);
  end

  logic [63:0] tx_got[$];
  logic [63:0] tx_exp[$];
  int          tx_cyc[$];
  logic [37:0] rsp_got[$];
  logic [37:0] rsp_exp[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && noc_tx_valid && noc_tx_ready) begin
      tx_got.push_back(noc_tx_flit);
      tx_cyc.push_back(cyc);
    end
    if (rst_n && rsp_valid && rsp_ready)
      rsp_got.push_back({rsp_data, rsp_src, rsp_last, rsp_empty});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] head_f(input logic [3:0] d, input logic [7:0] len,
                                         input logic [31:0] a);
    return {(len == 0) ? 2'b11 : 2'b01, d, 4'hF, len, 14'd0, a};
  endfunction

  function automatic logic [63:0] body_f(input logic [3:0] d, input int idx, input int len,
                                         input logic [31:0] w);
    logic [7:0] i8 = idx[7:0];
    return {(idx == len - 1) ? 2'b10 : 2'b00, d, 4'hF, 14'd0, i8, w};
  endfunction

  // Inbound reference: packet-level view of what the host should see.
  bit         m_in_pkt = 0;
  logic [3:0] m_src = '0;
  int         m_err = 0;

  task automatic rx_model(input logic [63:0] f);
    case (f[63:62])
      2'b01: begin
        if (m_in_pkt) m_err++;
        m_in_pkt = 1;
        m_src = f[57:54];
      end
      2'b11: begin
        if (m_in_pkt) m_err++;
        m_in_pkt = 0;
        rsp_exp.push_back({32'h0, f[57:54], 1'b1, 1'b1});
      end
      default: begin
        if (!m_in_pkt) m_err++;
        else begin
          rsp_exp.push_back({f[31:0], m_src, f[63:62] == 2'b10, 1'b0});
          if (f[63:62] == 2'b10) m_in_pkt = 0;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_in_pkt = 0; m_err = 0;
    tx_got.delete(); tx_exp.delete(); tx_cyc.delete();
    rsp_got.delete(); rsp_exp.delete();
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [3:0] d, input logic [31:0] a, input logic [7:0] len);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_dest = d; cmd_addr = a; cmd_len = len;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (cmd_ready) begin @(posedge clk); @(negedge clk); ok = 1; break; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("cmd_accept", ok, 1);
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok = 0;
    wd_valid = 1'b1; wd_data = w;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (wd_ready) begin @(posedge clk); @(negedge clk); ok = 1; break; end
      @(negedge clk);
    end
    wd_valid = 1'b0;
    check("wd_accept", ok, 1);
  endtask

  task automatic send_flit(input logic [63:0] f);
    bit ok = 0;
    noc_rx_valid = 1'b1; noc_rx_flit = f;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (noc_rx_ready) begin @(posedge clk); @(negedge clk); ok = 1; break; end
      @(negedge clk);
    end
    noc_rx_valid = 1'b0;
    check("rx_accept", ok, 1);
    rx_model(f);
  endtask

  task automatic tx_packet(input logic [3:0] d, input logic [31:0] a, input int len,
                           input bit gaps);
    logic [31:0] w;
    tx_exp.push_back(head_f(d, len[7:0], a));
    send_cmd(d, a, len[7:0]);
    for (int i = 0; i < len; i++) begin
      if (gaps) repeat ($urandom_range(2)) @(negedge clk);
      w = $urandom;
      tx_exp.push_back(body_f(d, i, len, w));
      send_word(w);
    end
  endtask

  task automatic tx_compare(input string tag);
    for (int n = 0; n < 500 && tx_got.size() < tx_exp.size(); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, tx_got.size(), tx_exp.size());
    while (tx_exp.size() > 0 && tx_got.size() > 0)
      check({tag, "_flit"}, tx_got.pop_front(), tx_exp.pop_front());
    tx_got.delete(); tx_exp.delete(); tx_cyc.delete();
  endtask

  task automatic rx_compare(input string tag);
    for (int n = 0; n < 500 && rsp_got.size() < rsp_exp.size(); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, rsp_got.size(), rsp_exp.size());
    while (rsp_exp.size() > 0 && rsp_got.size() > 0)
      check({tag, "_beat"}, rsp_got.pop_front(), rsp_exp.pop_front());
    rsp_got.delete(); rsp_exp.delete();
    check({tag, "_err"}, err_cnt, (m_err > 255) ? 255 : m_err);
  endtask

  initial begin
    logic [63:0] snap;
    logic [31:0] wa, wb, wc;
    int          span;
    cmd_valid = 0; cmd_dest = 0; cmd_addr = 0; cmd_len = 0;
    wd_valid = 0; wd_data = 0; noc_rx_valid = 0; noc_rx_flit = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl", {noc_tx_valid, cmd_ready, wd_ready, noc_rx_ready, rsp_valid,
                       tx_busy, rsp_last, rsp_empty}, 0);
    check("rst_tx_flit", noc_tx_flit, 0);
    check("rst_rsp", {rsp_data, rsp_src, err_cnt}, 0);
    do_reset();

    // Basic len=3 packet, sink always ready: four flits on consecutive cycles
    tx_man = 1;
    tx_packet(4'd2, 32'h0000_1000, 3, 0);
    repeat (3) @(negedge clk);
    span = (tx_cyc.size() >= 4) ? tx_cyc[3] - tx_cyc[0] : -1;
    check("t1_span", span, 3);
    tx_compare("t1");

    // Same packet with the first body flit stalled for three cycles
    wa = 32'hAAAA_0001; wb = 32'hBBBB_0002; wc = 32'hCCCC_0003;
    tx_exp.push_back(head_f(4'd2, 8'd3, 32'h0000_1000));
    tx_exp.push_back(body_f(4'd2, 0, 3, wa));
    tx_exp.push_back(body_f(4'd2, 1, 3, wb));
    tx_exp.push_back(body_f(4'd2, 2, 3, wc));
    send_cmd(4'd2, 32'h0000_1000, 8'd3);
    send_word(wa);
    tx_man = 0; wd_valid = 1; wd_data = wb;
    #1;
    snap = noc_tx_flit;
    check("t2_stalled_flit", snap, body_f(4'd2, 0, 3, wa));
    repeat (3) begin
      @(posedge clk); @(negedge clk); #1;
      check("t2_hold_valid", noc_tx_valid, 1);
      check("t2_hold_flit", noc_tx_flit, snap);
      check("t2_wd_ready_low", wd_ready, 0);
    end
    tx_man = 1;
    send_word(wb);
    send_word(wc);
    tx_compare("t2");

    // Two zero-length commands back to back
    tx_exp.push_back(head_f(4'd5, 8'd0, 32'h1234_5678));
    tx_exp.push_back(head_f(4'd6, 8'd0, 32'h9ABC_DEF0));
    cmd_valid = 1; cmd_dest = 4'd5; cmd_addr = 32'h1234_5678; cmd_len = 8'd0;
    #1;
    check("t3_cmd_ready_first", cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cmd_dest = 4'd6; cmd_addr = 32'h9ABC_DEF0;
    #1;
    check("t3_cmd_ready_next", cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    span = (tx_cyc.size() >= 2) ? tx_cyc[1] - tx_cyc[0] : -1;
    check("t3_span", span, 1);
    tx_compare("t3");

    // Random outbound packets under random backpressure
    tx_auto = 1; tx_bp = 35;
    for (int k = 0; k < 8; k++)
      tx_packet(4'($urandom_range(15)), $urandom, (k == 3) ? 17 : $urandom_range(5), 1);
    tx_compare("tx_rand");
    tx_auto = 0; tx_man = 1;

    // Inbound directed packets
    rsp_man = 1;
    send_flit({2'b01, 4'hF, 4'd1, 8'd2, 14'd0, 32'h0000_2000});
    send_flit({2'b00, 4'hF, 4'd1, 14'd0, 8'd0, 32'h0000_0011});
    send_flit({2'b10, 4'hF, 4'd1, 14'd0, 8'd1, 32'h0000_0022});
    send_flit({2'b11, 4'hF, 4'd3, 8'd0, 14'd0, 32'h0000_3000});
    rx_compare("t4");

    // Random inbound flit stream under random host backpressure
    rsp_auto = 1; rsp_bp = 40;
    for (int k = 0; k < 60; k++) begin
      logic [63:0] f;
      int r;
      r = $urandom_range(9);
      f = {$urandom, $urandom};
      f[63:62] = (r < 2) ? 2'b01 : (r < 3) ? 2'b11 : (r < 7) ? 2'b00 : 2'b10;
      repeat ($urandom_range(2)) @(negedge clk);
      send_flit(f);
    end
    rx_compare("rx_rand");
    rsp_auto = 0; rsp_man = 1;

    // Stray body flits: single error, then saturation
    do_reset();
    send_flit({2'b00, 4'hF, 4'd2, 14'd0, 8'd0, 32'h0000_0055});
    check("t5_err_one", err_cnt, 1);
    for (int k = 0; k < 299; k++)
      send_flit({2'b00, 4'hF, 4'd2, 14'd0, 8'd0, 32'h0000_0055});
    check("t5_err_sat", err_cnt, 255);
    rx_compare("t5");

    // Reset mid-body abandons the packet immediately
    do_reset();
    tx_man = 1;
    send_cmd(4'd7, 32'h0000_4000, 8'd4);
    send_word(32'h0BAD_F00D);
    #1;
    check("t6_busy_before", tx_busy, 1);
    rst_n = 0;
    #1;
    check("t6_tx_valid", noc_tx_valid, 0);
    check("t6_cmd_ready", cmd_ready, 0);
    check("t6_tx_busy", tx_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    tx_got.delete(); tx_exp.delete(); tx_cyc.delete();
    tx_packet(4'd9, 32'h0000_5000, 1, 0);
    tx_compare("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
